// File: rtl/regfile_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
//
// Read side of the MIPS register file. Picks two operands out of the flattened
// register array bus, registers them, and hands them to decode/issue over a
// valid/ready handshake with one cycle of latency. Index 0 reads as zero when
// ZERO_REG is set, and addresses beyond the populated array read as zero.
//
// Optional feature (compile-time macro READ_BYPASS_EN):
//   defined   - a write landing in the array on the same edge as an accepted
//               read is forwarded, so the read returns the new value.
//   undefined - no forwarding; the write port inputs are ignored.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   regBus     in   NREG*WIDTH concatenated register outputs (reg i at i*WIDTH)
//   regWrite   in   companion write port strobe (same edge the array captures)
//   writeAddr  in   AW   register written this cycle
//   writeData  in   WIDTH data written this cycle
//   reqValid   in   read request valid
//   reqReady   out  port can accept a request this cycle
//   rs, rt     in   AW   read addresses for operand 1 / operand 2
//   rspValid   out  readData1/readData2 valid
//   rspReady   in   consumer accepts the response
//   readData1  out  WIDTH operand for rs
//   readData2  out  WIDTH operand for rt
//   readCount  out  16   requests accepted since reset (wraps)
// -----------------------------------------------------------------------------
module regfile_read_port #(
    parameter int WIDTH    = 32,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREG*WIDTH-1:0] regBus,
    input  logic                  regWrite,
    input  logic [AW-1:0]         writeAddr,
    input  logic [WIDTH-1:0]      writeData,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic [AW-1:0]         rs,
    input  logic [AW-1:0]         rt,
    output logic                  rspValid,
    input  logic                  rspReady,
    output logic [WIDTH-1:0]      readData1,
    output logic [WIDTH-1:0]      readData2,
    output logic [15:0]           readCount
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic             accept;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;

    // The output register is the only storage, so a response slot frees up
    // in the same cycle the consumer takes the current one.
    assign rspValid = (state == FULL);
    assign reqReady = !rspValid || rspReady;
    assign accept   = reqValid && reqReady;

    // Array slice at addr; unpopulated addresses and (optionally) index 0
    // read as zero.
    function automatic logic [WIDTH-1:0] slice_at(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] value;
        // NOTE: default the result before the conditional assignments so no
        // path leaves it unassigned (which would infer a latch in comb logic).
        value = '0;
        for (int i = 0; i < NREG; i++) begin
            if (addr == AW'(i)) value = regBus[i*WIDTH +: WIDTH];
        end
        if (ZERO_REG != 0 && addr == '0) value = '0;
        return value;
    endfunction

`ifdef READ_BYPASS_EN
    // A write to $zero is never forwarded, otherwise the zero convention
    // would leak the written value for one read.
    function automatic logic [WIDTH-1:0] operand_for(input logic [AW-1:0] addr);
        if (regWrite && writeAddr == addr && !(ZERO_REG != 0 && writeAddr == '0))
            return writeData;
        return slice_at(addr);
    endfunction
`else
    function automatic logic [WIDTH-1:0] operand_for(input logic [AW-1:0] addr);
        return slice_at(addr);
    endfunction

    // Write port is not observed in this build.
    logic unused_write_port;
    assign unused_write_port = ^{regWrite, writeAddr, writeData};
`endif

    always_comb begin
        operand1 = operand_for(rs);
        operand2 = operand_for(rt);
    end

    // Data registers only load on accept, so a stalled response stays a
    // bit-stable snapshot even if the array changes underneath it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            readData1 <= '0;
            readData2 <= '0;
            readCount <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            case (state)
                EMPTY:   if (accept) state <= FULL;
                FULL:    if (rspReady && !accept) state <= EMPTY;
                default: state <= EMPTY;
            endcase
            if (accept) begin
                readData1 <= operand1;
                readData2 <= operand2;
                readCount <= readCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_port.sv
module tb_regfile_read_port;

    logic          clk;
    logic          reset;
    logic [1023:0] regBus;
    logic          regWrite;
    logic [4:0]    writeAddr;
    logic [31:0]   writeData;
    logic          reqValid;
    logic          reqReady;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic          rspValid;
    logic          rspReady;
    logic [31:0]   readData1;
    logic [31:0]   readData2;
    logic [15:0]   readCount;

    regfile_read_port dut (
        .clk       (clk),
        .reset     (reset),
        .regBus    (regBus),
        .regWrite  (regWrite),
        .writeAddr (writeAddr),
        .writeData (writeData),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .rs        (rs),
        .rt        (rt),
        .rspValid  (rspValid),
        .rspReady  (rspReady),
        .readData1 (readData1),
        .readData2 (readData2),
        .readCount (readCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register array contents as seen by the read port.
    logic [31:0] regs [32];

    always_comb begin
        regBus = '0;
        for (int i = 0; i < 32; i++) regBus[i*32 +: 32] = regs[i];
    end

    int checks = 0;
    int errors = 0;

    // Reference model: what the consumer should see.
    logic        exp_valid;
    logic [31:0] exp_d1;
    logic [31:0] exp_d2;
    int          exp_count;
    logic        last_acc;

    // Value a read of address a must return this cycle.
    function automatic logic [31:0] ref_read(input int a);
        if (a == 0) return 32'h0;
`ifdef READ_BYPASS_EN
        if (regWrite && int'(writeAddr) == a) return writeData;
`endif
        return regs[a];
    endfunction

    // One clock: model decides accept/drain from pre-edge inputs, then the
    // array commits any write.
    task automatic advance();
        logic        rdy;
        logic        acc;
        logic [31:0] n1;
        logic [31:0] n2;
        rdy = !exp_valid || rspReady;
        acc = reqValid && rdy;
        n1  = ref_read(int'(rs));
        n2  = ref_read(int'(rt));
        @(posedge clk);
        #1;
        last_acc = acc;
        if (acc) begin
            exp_valid = 1'b1;
            exp_d1    = n1;
            exp_d2    = n2;
            exp_count = (exp_count + 1) % 65536;
        end else if (rspReady) begin
            exp_valid = 1'b0;
        end
        if (regWrite) regs[writeAddr] = writeData;
    endtask

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_d1    = '0;
        exp_d2    = '0;
        exp_count = 0;
        last_acc  = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        #2;
        checks++; if (rspValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rspValid); end
        checks++; if (readData1 !== 32'h0) begin errors++; $display("FAIL reset_d1 got %h want 0", readData1); end
        checks++; if (readData2 !== 32'h0) begin errors++; $display("FAIL reset_d2 got %h want 0", readData2); end
        checks++; if (readCount !== 16'h0) begin errors++; $display("FAIL reset_count got %h want 0", readCount); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", reqReady); end
        advance();
        checks++; if (rspValid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", rspValid); end
    endtask

    task automatic test_basic();
        regs[5]  = 32'hDEADBEEF;
        regs[9]  = 32'h12345678;
        rspReady = 1'b1;
        reqValid = 1'b1;
        rs = 5'd5;
        rt = 5'd9;
        advance();
        reqValid = 1'b0;
        checks++; if (rspValid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", rspValid); end
        checks++; if (readData1 !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_d1 got %h want deadbeef", readData1); end
        checks++; if (readData2 !== 32'h12345678) begin errors++; $display("FAIL basic_d2 got %h want 12345678", readData2); end
        checks++; if (readCount !== 16'd1) begin errors++; $display("FAIL basic_count got %0d want 1", readCount); end
        advance();
        checks++; if (rspValid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b want 0", rspValid); end
    endtask

    task automatic test_zero();
        regs[0]  = 32'hFFFFFFFF;
        reqValid = 1'b1;
        rs = 5'd0;
        rt = 5'd0;
        advance();
        checks++; if (readData1 !== 32'h0) begin errors++; $display("FAIL zero_d1 got %h want 0", readData1); end
        checks++; if (readData2 !== 32'h0) begin errors++; $display("FAIL zero_d2 got %h want 0", readData2); end
        rs = 5'd9;
        rt = 5'd9;
        advance();
        reqValid = 1'b0;
        checks++; if (readData1 !== 32'h12345678 || readData2 !== 32'h12345678) begin
            errors++; $display("FAIL same_addr got %h/%h want 12345678/12345678", readData1, readData2);
        end
        advance();
    endtask

    task automatic test_backpressure();
        int cnt;
        reqValid = 1'b1;
        rs = 5'd5;
        rt = 5'd9;
        rspReady = 1'b1;
        advance();
        cnt = exp_count;
        rspReady  = 1'b0;
        regWrite  = 1'b1;
        writeAddr = 5'd5;
        writeData = 32'h1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (reqReady !== 1'b0) begin errors++; $display("FAIL bp_ready cycle %0d got %b want 0", i, reqReady); end
            advance();
            checks++; if (readData1 !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_hold cycle %0d got %h want deadbeef", i, readData1); end
            checks++; if (rspValid !== 1'b1) begin errors++; $display("FAIL bp_valid cycle %0d got %b want 1", i, rspValid); end
            checks++; if (int'(readCount) != cnt) begin errors++; $display("FAIL bp_count cycle %0d got %0d want %0d", i, readCount, cnt); end
        end
        regWrite = 1'b0;
        rspReady = 1'b1;
        #1;
        checks++; if (reqReady !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", reqReady); end
        advance();
        reqValid = 1'b0;
        checks++; if (readData1 !== 32'h1) begin errors++; $display("FAIL bp_newdata got %h want 1", readData1); end
        advance();
    endtask

    task automatic test_bypass();
        logic [31:0] want;
`ifdef READ_BYPASS_EN
        want = 32'hCAFEF00D;
`else
        want = 32'h0;
`endif
        regs[7]   = 32'h0;
        regWrite  = 1'b1;
        writeAddr = 5'd7;
        writeData = 32'hCAFEF00D;
        reqValid  = 1'b1;
        rs = 5'd7;
        rt = 5'd9;
        advance();
        checks++; if (readData1 !== want) begin errors++; $display("FAIL bypass_d1 got %h want %h", readData1, want); end
        checks++; if (readData2 !== 32'h12345678) begin errors++; $display("FAIL bypass_d2 got %h want 12345678", readData2); end
        regWrite = 1'b0;
        advance();
        checks++; if (readData1 !== 32'hCAFEF00D) begin errors++; $display("FAIL bypass_after got %h want cafef00d", readData1); end
        regWrite  = 1'b1;
        writeAddr = 5'd0;
        writeData = 32'h55555555;
        rs = 5'd0;
        rt = 5'd7;
        advance();
        checks++; if (readData1 !== 32'h0) begin errors++; $display("FAIL bypass_zero got %h want 0", readData1); end
        checks++; if (readData2 !== 32'hCAFEF00D) begin errors++; $display("FAIL bypass_zero_rt got %h want cafef00d", readData2); end
        regWrite = 1'b0;
        reqValid = 1'b0;
        advance();
    endtask

    task automatic test_back_to_back();
        rspReady = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            reqValid = 1'b1;
            rs = 5'($urandom);
            rt = 5'($urandom);
            advance();
            checks++; if (rspValid !== 1'b1) begin errors++; $display("FAIL b2b_valid %0d got %b want 1", i, rspValid); end
            checks++; if (readData1 !== exp_d1 || readData2 !== exp_d2) begin
                errors++; $display("FAIL b2b_data %0d got %h/%h want %h/%h", i, readData1, readData2, exp_d1, exp_d2);
            end
        end
        checks++; if (readCount !== 16'd4) begin errors++; $display("FAIL b2b_count got %0d want 4", readCount); end
        reqValid = 1'b0;
        reset = 1'b1;
        model_reset();
        #1;
        checks++; if (rspValid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b want 0", rspValid); end
        checks++; if (readCount !== 16'd0) begin errors++; $display("FAIL midreset_count got %0d want 0", readCount); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        advance();
        checks++; if (rspValid !== 1'b0) begin errors++; $display("FAIL midreset_replay got %b want 0", rspValid); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        for (int n = 0; n < 400; n++) begin
            // Requester holds a stalled request unchanged until it is taken.
            if (!(reqValid && !last_acc)) begin
                reqValid = ($urandom_range(0, 3) != 0);
                rs = 5'($urandom);
                rt = ($urandom_range(0, 7) == 0) ? rs : 5'($urandom);
            end
            rspReady  = ($urandom_range(0, 2) != 0);
            regWrite  = ($urandom_range(0, 1) != 0);
            writeAddr = ($urandom_range(0, 1) != 0) ? rs : 5'($urandom);
            writeData = $urandom;
            #1;
            checks++; if (reqReady !== (!exp_valid || rspReady)) begin
                errors++; $display("FAIL rnd_ready %0d got %b want %b", n, reqReady, (!exp_valid || rspReady));
            end
            advance();
            checks++; if (rspValid !== exp_valid) begin errors++; $display("FAIL rnd_valid %0d got %b want %b", n, rspValid, exp_valid); end
            checks++; if (readData1 !== exp_d1 || readData2 !== exp_d2) begin
                errors++; $display("FAIL rnd_data %0d got %h/%h want %h/%h", n, readData1, readData2, exp_d1, exp_d2);
            end
            checks++; if (int'(readCount) != exp_count) begin errors++; $display("FAIL rnd_count %0d got %0d want %0d", n, readCount, exp_count); end
        end
        reqValid = 1'b0;
        regWrite = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        reset     = 1'b1;
        regWrite  = 1'b0;
        writeAddr = '0;
        writeData = '0;
        reqValid  = 1'b0;
        rspReady  = 1'b0;
        rs        = '0;
        rt        = '0;
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_bypass();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
- Read side of the MIPS register file. Selects two 32-bit operands from the flattened output buses of the 32 register32bit instances.
- Registers the selected operands and returns them over a valid/ready handshake with 1-cycle latency.
- Enforces the $zero convention and optionally forwards a same-cycle write.
- Sits between the register array and decode/issue.

Parameters:
- WIDTH, 32, data width of each register.
- NREG, 32, number of registers in the array.
- AW, 5, address width (log2 NREG).
- ZERO_REG, 1, when 1 register index 0 always reads as 0.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- regBus  input  NREG*WIDTH  concatenated register outputs; register i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH].
- regWrite  input  1  write strobe of the companion write port (same cycle the array captures).
- writeAddr  input  AW  register being written this cycle.
- writeData  input  WIDTH  data being written this cycle.
- reqValid  input  1  read request valid.
- reqReady  output  1  port can accept a request this cycle.
- rs  input  AW  first read address.
- rt  input  AW  second read address.
- rspValid  output  1  readData1/readData2 valid.
- rspReady  input  1  consumer accepts the response.
- readData1  output  WIDTH  operand for rs.
- readData2  output  WIDTH  operand for rt.
- readCount  output  16  number of requests accepted since reset.

Behaviour:
- Reset (async, active-high, clears immediately): rspValid=0, readData1=0, readData2=0, readCount=0. reqReady=1 as soon as reset deasserts.
- Single-entry output register, two states:
  - EMPTY: rspValid=0.
  - FULL: rspValid=1.
- reqReady = !rspValid || rspReady. This is combinational, giving full throughput of 1 request/cycle.
- Accept: reqValid && reqReady at a rising edge.
  - On accept, capture both operands; rspValid=1 next cycle (latency 1). readCount increments.
  - readCount wraps 0xFFFF -> 0x0000.
- Transitions:
  - EMPTY + accept -> FULL.
  - FULL + rspReady + accept -> FULL with new data.
  - FULL + rspReady + no accept -> EMPTY.
  - FULL + !rspReady -> FULL; readData1/readData2 held bit-stable.
- Operand select: readDataN = regBus slice at address.
  - If ZERO_REG=1 and address==0, the result is 0 regardless of regBus contents.
- Held response is a snapshot. A later write to rs/rt while stalled does NOT update readData1/readData2.
- rs==rt: both outputs carry identical values.
- Address >= NREG (when NREG < 2**AW): reads 0.
- Reset mid-transaction: the held response is discarded, rspValid drops immediately, and the response is not replayed.
- reqValid while !reqReady: no capture, no count change. The requester must hold rs/rt stable until accepted.

Optional Feature:
- Macro READ_BYPASS_EN.
- When defined: on accept, if regWrite && writeAddr==rs (and not (ZERO_REG && writeAddr==0)), readData1 captures writeData instead of the regBus slice. Same rule applies to rt/readData2. Write-then-read in the same cycle returns the new value.
- When undefined: no forwarding. A same-cycle write returns the pre-write regBus value. regWrite/writeAddr/writeData are unused.

Test Plan:
- Reset then idle: after reset, rspValid=0, readData1=readData2=0, readCount=0, reqReady=1.
- Basic read: reg5=0xDEADBEEF, reg9=0x12345678. Request rs=5, rt=9 with rspReady=1 -> next cycle rspValid=1, readData1=0xDEADBEEF, readData2=0x12345678, readCount=1.
- $zero: regBus slice 0 forced to 0xFFFFFFFF. Request rs=0, rt=0 -> both outputs 0x00000000.
- Back-pressure: accept rs=5, then hold rspReady=0 for 3 cycles while writing reg5=0x1 -> reqReady=0, readData1 stays 0xDEADBEEF, readCount unchanged. Raise rspReady -> reqReady=1 in the same cycle.
- Bypass: same cycle regWrite=1, writeAddr=7, writeData=0xCAFEF00D, request rs=7, reg7 old=0x0.
  - With READ_BYPASS_EN: readData1=0xCAFEF00D.
  - Without it: readData1=0x0.
  - writeAddr=0 -> readData1=0 in both builds.
- Throughput/reset: 4 back-to-back requests with rspReady=1 -> 4 consecutive valid responses, readCount=4. Assert reset while rspValid=1 -> rspValid=0 immediately, readCount=0.
